shop_cmd_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one shop_v command port among NUM_REQ front-end terminals.
- Each terminal posts a user number and an ASCII command key. The arbiter grants one terminal at a time and drives the shop's i_u/i_a/i_rdy strobe sequence.
- After the shop's response window it captures the shop's o_a and returns it to the granted terminal with a one-cycle ack.

---
 rtl/shop_cmd_arbiter_if.sv | 30 +++
 rtl/shop_cmd_arbiter.sv | 172 +++++++++++++++++
 tb/tb_shop_cmd_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shop_cmd_arbiter_if.sv
// Terminal request/ack bus and shop_v command port shared by shop_cmd_arbiter and its environment.
// master: terminals and shop drive the i_* side; slave: the arbiter drives the o_* side.
interface shop_cmd_arbiter_if #(
    parameter int NUM_REQ             = 4,
    parameter int I_U_NUM_BITS        = 4,
    parameter int I_A_NUM_ASCII_CHARS = 7,
    parameter int O_A_NUM_ASCII_CHARS = 9
);
    logic [NUM_REQ-1:0]                     i_req;
    logic [NUM_REQ*I_U_NUM_BITS-1:0]        i_req_u;
    logic [NUM_REQ*I_A_NUM_ASCII_CHARS*8-1:0] i_req_a;
    logic [NUM_REQ-1:0]                     o_ack;
    logic [O_A_NUM_ASCII_CHARS*8-1:0]       o_rsp_a;
    logic [2:0]                             o_rsp_id;
    logic                                   o_busy;
    logic                                   o_shop_rdy;
    logic [I_U_NUM_BITS-1:0]                o_shop_u;
    logic [I_A_NUM_ASCII_CHARS*8-1:0]       o_shop_a;
    logic [O_A_NUM_ASCII_CHARS*8-1:0]       i_shop_a;

    modport master (
        output i_req, i_req_u, i_req_a, i_shop_a,
        input  o_ack, o_rsp_a, o_rsp_id, o_busy, o_shop_rdy, o_shop_u, o_shop_a
    );

    modport slave (
        input  i_req, i_req_u, i_req_a, i_shop_a,
        output o_ack, o_rsp_a, o_rsp_id, o_busy, o_shop_rdy, o_shop_u, o_shop_a
    );
endinterface

// File: rtl/shop_cmd_arbiter.sv
// Round-robin arbiter sequencing NUM_REQ terminals onto one shop_v command port.
// Optional macro SHOP_ARB_CMD_FILTER_EN answers unknown commands with "BadCmd" without strobing the shop.
module shop_cmd_arbiter #(
    parameter int NUM_REQ             = 4,
    parameter int I_U_NUM_BITS        = 4,
    parameter int I_A_NUM_ASCII_CHARS = 7,
    parameter int O_A_NUM_ASCII_CHARS = 9,
    parameter int RESP_WAIT           = 3
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    shop_cmd_arbiter_if.slave  bus
);
    localparam int CMD_W = 8 * I_A_NUM_ASCII_CHARS;
    localparam int RSP_W = 8 * O_A_NUM_ASCII_CHARS;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(RESP_WAIT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [I_U_NUM_BITS-1:0] shop_u_q, shop_u_d;
    logic [CMD_W-1:0]        shop_a_q, shop_a_d;
    logic                    shop_rdy_q, shop_rdy_d;
    logic                    busy_q, busy_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [RSP_W-1:0]        rsp_a_q, rsp_a_d;
    logic [2:0]              rsp_id_q, rsp_id_d;
`ifdef SHOP_ARB_CMD_FILTER_EN
    logic                    bad_q, bad_d;
`endif

    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W:0]          scan_idx;
    logic [CMD_W-1:0]        pick_a;
    logic [I_U_NUM_BITS-1:0] pick_u;

`ifdef SHOP_ARB_CMD_FILTER_EN
    function automatic logic cmd_is_key(input logic [CMD_W-1:0] c);
        return (c == CMD_W'("Logout"))  || (c == CMD_W'("Login"))   ||
               (c == CMD_W'("AddUsr"))  || (c == CMD_W'("DelUsr"))  ||
               (c == CMD_W'("AddItem")) || (c == CMD_W'("DelItem")) ||
               (c == CMD_W'("Buy"));
    endfunction
`endif

    // First requesting terminal at or above the rr pointer, wrapping past NUM_REQ-1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (scan_idx >= (IDX_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!pick_found && bus.i_req[scan_idx[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[IDX_W-1:0];
            end
        end
        pick_u = bus.i_req_u[int'(pick_idx)*I_U_NUM_BITS +: I_U_NUM_BITS];
        pick_a = bus.i_req_a[int'(pick_idx)*CMD_W +: CMD_W];
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        shop_u_d   = shop_u_q;
        shop_a_d   = shop_a_q;
        shop_rdy_d = 1'b0;
        ack_d      = '0;
        rsp_a_d    = rsp_a_q;
        rsp_id_d   = rsp_id_q;
`ifdef SHOP_ARB_CMD_FILTER_EN
        bad_d      = bad_q;
`endif
        unique case (state_q)
            IDLE: begin
                // A pending ack marks the first IDLE cycle; holding off here stops the acked terminal being regranted.
                if (pick_found && (ack_q == '0)) begin
                    grant_d  = pick_idx;
                    rr_d     = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
                    shop_u_d = pick_u;
                    shop_a_d = pick_a;
`ifdef SHOP_ARB_CMD_FILTER_EN
                    bad_d    = !cmd_is_key(pick_a);
                    state_d  = cmd_is_key(pick_a) ? SETUP : RESP;
`else
                    state_d  = SETUP;
`endif
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                shop_rdy_d = 1'b1;
                cnt_d      = CNT_W'(RESP_WAIT);
                state_d    = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ack_d    = NUM_REQ'(1) << grant_q;
                rsp_id_d = 3'(grant_q);
`ifdef SHOP_ARB_CMD_FILTER_EN
                rsp_a_d  = bad_q ? RSP_W'("BadCmd") : bus.i_shop_a;
`else
                rsp_a_d  = bus.i_shop_a;
`endif
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            shop_u_q   <= '0;
            shop_a_q   <= '0;
            shop_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            rsp_a_q    <= '0;
            rsp_id_q   <= '0;
`ifdef SHOP_ARB_CMD_FILTER_EN
            bad_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            shop_u_q   <= shop_u_d;
            shop_a_q   <= shop_a_d;
            shop_rdy_q <= shop_rdy_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            rsp_a_q    <= rsp_a_d;
            rsp_id_q   <= rsp_id_d;
`ifdef SHOP_ARB_CMD_FILTER_EN
            bad_q      <= bad_d;
`endif
        end
    end

    assign bus.o_ack      = ack_q;
    assign bus.o_rsp_a    = rsp_a_q;
    assign bus.o_rsp_id   = rsp_id_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_shop_rdy = shop_rdy_q;
    assign bus.o_shop_u   = shop_u_q;
    assign bus.o_shop_a   = shop_a_q;
endmodule

// File: tb/tb_shop_cmd_arbiter.sv
// Self-checking bench for shop_cmd_arbiter: randomized terminals and a simple shop model against a queue-based reference.
module tb_shop_cmd_arbiter;
    localparam int NR = 4;
    localparam int UW = 4;
    localparam int CW = 56;
    localparam int RW = 72;
    localparam int RESP_WAIT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    shop_cmd_arbiter_if #(.NUM_REQ(NR), .I_U_NUM_BITS(UW), .I_A_NUM_ASCII_CHARS(7),
                          .O_A_NUM_ASCII_CHARS(9)) bus ();

    shop_cmd_arbiter #(.NUM_REQ(NR), .I_U_NUM_BITS(UW), .I_A_NUM_ASCII_CHARS(7),
                       .O_A_NUM_ASCII_CHARS(9), .RESP_WAIT(RESP_WAIT)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [CW-1:0] cmd_key(input int k);
        case (k)
            0: return CW'("Logout");
            1: return CW'("Login");
            2: return CW'("AddUsr");
            3: return CW'("DelUsr");
            4: return CW'("AddItem");
            5: return CW'("DelItem");
            6: return CW'("Buy");
            7: return CW'("NONE");
            default: return CW'("hi");
        endcase
    endfunction

    function automatic bit forwarded(input int k);
`ifdef SHOP_ARB_CMD_FILTER_EN
        return (k <= 6);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [RW-1:0] shop_resp(input logic [UW-1:0] u, input logic [CW-1:0] a);
        if (a == CW'("Login")) return RW'("LoggedIn");
        return {8'h52, 4'h3, u, a};
    endfunction

    // Shop model: latches its answer on the strobe and holds it on o_a.
    logic [RW-1:0] shop_a = '0;
    always @(posedge clk) if (bus.o_shop_rdy) shop_a <= shop_resp(bus.o_shop_u, bus.o_shop_a);
    assign bus.i_shop_a = shop_a;

    int            term_k [NR];
    logic [UW-1:0] term_u [NR];
    int            mrr;
    int            exp_id [$];

    int            g_cyc [$];
    int            s_cyc [$];
    logic [UW-1:0] s_u [$];
    logic [CW-1:0] s_a [$];
    int            a_cyc [$];
    logic [NR-1:0] a_val [$];
    logic [RW-1:0] a_rsp [$];
    logic [2:0]    a_id [$];
    logic [NR-1:0] drop_pend = '0;
    logic          prev_busy = 1'b0;

    task automatic set_term(input int n, input logic [UW-1:0] u, input int k);
        term_u[n] = u;
        term_k[n] = k;
        bus.i_req_u[n*UW +: UW] = u;
        bus.i_req_a[n*CW +: CW] = cmd_key(k);
    endtask

    // Reference: pending terminals are served in pointer order, pointer moving past each winner.
    task automatic model_serve(input logic [NR-1:0] mask);
        logic [NR-1:0] pend;
        pend = mask;
        while (pend != '0) begin
            for (int i = 0; i < NR; i++) begin
                int t;
                t = (mrr + i) % NR;
                if (pend[t]) begin
                    exp_id.push_back(t);
                    pend[t] = 1'b0;
                    mrr = (t + 1) % NR;
                    break;
                end
            end
        end
    endtask

    task automatic clear_log();
        g_cyc.delete(); s_cyc.delete(); s_u.delete(); s_a.delete();
        a_cyc.delete(); a_val.delete(); a_rsp.delete(); a_id.delete();
        exp_id.delete();
    endtask

    // One cycle: terminals drop i_req the cycle after their ack; outputs logged on the falling edge.
    task automatic step();
        @(negedge clk);
        bus.i_req = bus.i_req & ~drop_pend;
        drop_pend = bus.o_ack;
        if (bus.o_busy && !prev_busy) g_cyc.push_back(cyc);
        prev_busy = bus.o_busy;
        if (bus.o_shop_rdy) begin
            s_cyc.push_back(cyc); s_u.push_back(bus.o_shop_u); s_a.push_back(bus.o_shop_a);
        end
        if (bus.o_ack != '0) begin
            a_cyc.push_back(cyc); a_val.push_back(bus.o_ack);
            a_rsp.push_back(bus.o_rsp_a); a_id.push_back(bus.o_rsp_id);
        end
    endtask

    task automatic run_until_acks(input int n, input int budget, output bit timeout);
        int c;
        c = 0;
        while (a_cyc.size() < n && c < budget) begin
            step();
            c++;
        end
        timeout = (a_cyc.size() < n);
        repeat (6) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_req = '0;
        drop_pend = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mrr = 0;
        prev_busy = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_req = '0;
        bus.i_req_u = '0;
        bus.i_req_a = '0;
        #12;
        checks++; if (bus.o_ack !== '0) $display("[TB] FAIL reset_ack got %b want 0", bus.o_ack); else passed++;
        checks++; if (bus.o_busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", bus.o_busy); else passed++;
        checks++; if (bus.o_shop_rdy !== 1'b0) $display("[TB] FAIL reset_rdy got %b want 0", bus.o_shop_rdy); else passed++;
        checks++; if (bus.o_rsp_a !== '0 || bus.o_rsp_id !== '0) $display("[TB] FAIL reset_rsp got %h/%0d want 0/0", bus.o_rsp_a, bus.o_rsp_id); else passed++;
        checks++; if (bus.o_shop_u !== '0 || bus.o_shop_a !== '0) $display("[TB] FAIL reset_shop got %h/%h want 0/0", bus.o_shop_u, bus.o_shop_a); else passed++;
        do_reset();
    endtask

    task automatic test_single();
        bit to;
        set_term(0, 4'd4, 1);
        bus.i_req = 4'b0001;
        model_serve(4'b0001);
        run_until_acks(1, 40, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL single_timeout got no ack want ack"); else passed++;
        checks++; if (g_cyc.size() != 1 || s_cyc.size() != 1) $display("[TB] FAIL single_counts got grants=%0d strobes=%0d want 1/1", g_cyc.size(), s_cyc.size()); else passed++;
        if (g_cyc.size() == 1 && s_cyc.size() == 1 && a_cyc.size() == 1) begin
            checks++; if (s_u[0] !== 4'd4 || s_a[0] !== CW'("Login")) $display("[TB] FAIL single_shop_data got %0d/%h want 4/Login", s_u[0], s_a[0]); else passed++;
            checks++; if (s_cyc[0] - g_cyc[0] != 2) $display("[TB] FAIL single_rdy_lat got %0d want 2", s_cyc[0] - g_cyc[0]); else passed++;
            checks++; if (a_cyc[0] - g_cyc[0] != 3 + RESP_WAIT) $display("[TB] FAIL single_ack_lat got %0d want %0d", a_cyc[0] - g_cyc[0], 3 + RESP_WAIT); else passed++;
            checks++; if (a_val[0] !== 4'b0001 || a_id[0] !== 3'(exp_id[0])) $display("[TB] FAIL single_ack got %b/%0d want 0001/%0d", a_val[0], a_id[0], exp_id[0]); else passed++;
            checks++; if (a_rsp[0] !== RW'("LoggedIn")) $display("[TB] FAIL single_rsp got %h want LoggedIn", a_rsp[0]); else passed++;
        end
        checks++; if (bus.o_busy !== 1'b0 || bus.o_rsp_a !== RW'("LoggedIn") || bus.o_shop_u !== 4'd4) $display("[TB] FAIL single_hold got busy=%b rsp=%h u=%0d want 0/LoggedIn/4", bus.o_busy, bus.o_rsp_a, bus.o_shop_u); else passed++;
    endtask

    task automatic test_simultaneous();
        bit to;
        logic [NR-1:0] one;
        one = 1;
        do_reset();
        for (int n = 0; n < NR; n++) set_term(n, UW'($urandom), int'($urandom_range(0, 6)));
        bus.i_req = 4'b1111;
        model_serve(4'b1111);
        run_until_acks(4, 120, to);
        checks++; if (to !== 1'b0 || a_cyc.size() != 4) $display("[TB] FAIL simul_acks got %0d want 4", a_cyc.size()); else passed++;
        checks++; if (s_cyc.size() != 4) $display("[TB] FAIL simul_strobes got %0d want 4", s_cyc.size()); else passed++;
        for (int i = 0; i < a_cyc.size() && i < exp_id.size(); i++) begin
            checks++; if (a_val[i] !== (one << exp_id[i]) || a_id[i] !== 3'(exp_id[i])) $display("[TB] FAIL simul_order[%0d] got %b/%0d want id %0d", i, a_val[i], a_id[i], exp_id[i]); else passed++;
            checks++; if (a_rsp[i] !== shop_resp(term_u[exp_id[i]], cmd_key(term_k[exp_id[i]]))) $display("[TB] FAIL simul_rsp[%0d] got %h", i, a_rsp[i]); else passed++;
        end
        for (int i = 1; i < s_cyc.size(); i++) begin
            checks++; if (s_cyc[i] - s_cyc[i-1] != 5 + RESP_WAIT) $display("[TB] FAIL simul_spacing[%0d] got %0d want %0d", i, s_cyc[i] - s_cyc[i-1], 5 + RESP_WAIT); else passed++;
        end
    endtask

    task automatic test_wrap();
        bit to;
        do_reset();
        set_term(2, 4'd9, 6);
        bus.i_req = 4'b0100;
        model_serve(4'b0100);
        run_until_acks(1, 40, to);
        clear_log();
        set_term(0, 4'd1, 2);
        set_term(2, 4'd2, 3);
        bus.i_req = 4'b0101;
        model_serve(4'b0101);
        run_until_acks(2, 60, to);
        checks++; if (to !== 1'b0 || a_id.size() != 2) $display("[TB] FAIL wrap_acks got %0d want 2", a_id.size()); else passed++;
        for (int i = 0; i < a_id.size() && i < exp_id.size(); i++) begin
            checks++; if (a_id[i] !== 3'(exp_id[i])) $display("[TB] FAIL wrap_order[%0d] got %0d want %0d", i, a_id[i], exp_id[i]); else passed++;
        end
    endtask

    task automatic test_early_drop();
        bit to;
        int c;
        clear_log();
        set_term(1, 4'd7, 4);
        bus.i_req = 4'b0010;
        model_serve(4'b0010);
        c = 0;
        while (s_cyc.size() == 0 && c < 20) begin step(); c++; end
        checks++; if (s_cyc.size() != 1) $display("[TB] FAIL drop_strobe_wait got %0d strobes want 1", s_cyc.size()); else passed++;
        step();
        bus.i_req[1] = 1'b0;
        run_until_acks(1, 20, to);
        checks++; if (to !== 1'b0 || a_val.size() != 1) $display("[TB] FAIL drop_ack_count got %0d want 1", a_val.size()); else passed++;
        if (a_val.size() == 1) begin
            checks++; if (a_val[0] !== 4'b0010 || a_id[0] !== 3'(exp_id[0])) $display("[TB] FAIL drop_ack got %b/%0d want 0010/1", a_val[0], a_id[0]); else passed++;
        end
        checks++; if (s_cyc.size() != 1 || g_cyc.size() != 1) $display("[TB] FAIL drop_once got strobes=%0d grants=%0d want 1/1", s_cyc.size(), g_cyc.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        bit to;
        int c;
        clear_log();
        set_term(0, 4'd3, 0);
        set_term(1, 4'd5, 5);
        bus.i_req = 4'b0001;
        c = 0;
        while (s_cyc.size() == 0 && c < 20) begin step(); c++; end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_ack !== '0 || bus.o_busy !== 1'b0 || bus.o_shop_rdy !== 1'b0) $display("[TB] FAIL midreset_outputs got ack=%b busy=%b rdy=%b want 0", bus.o_ack, bus.o_busy, bus.o_shop_rdy); else passed++;
        bus.i_req = 4'b0011;
        drop_pend = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mrr = 0;
        prev_busy = 1'b0;
        clear_log();
        model_serve(4'b0011);
        run_until_acks(2, 60, to);
        checks++; if (to !== 1'b0 || a_id.size() != 2) $display("[TB] FAIL midreset_acks got %0d want 2", a_id.size()); else passed++;
        for (int i = 0; i < a_id.size() && i < exp_id.size(); i++) begin
            checks++; if (a_id[i] !== 3'(exp_id[i])) $display("[TB] FAIL midreset_order[%0d] got %0d want %0d", i, a_id[i], exp_id[i]); else passed++;
        end
    endtask

    task automatic test_filter();
        bit to;
        logic [RW-1:0] want_rsp;
        int want_lat;
        int want_str;
        clear_log();
        set_term(3, 4'd6, 8);
        bus.i_req = 4'b1000;
        model_serve(4'b1000);
        want_str = forwarded(8) ? 1 : 0;
        want_lat = forwarded(8) ? 3 + RESP_WAIT : 1;
        want_rsp = forwarded(8) ? shop_resp(4'd6, cmd_key(8)) : RW'("BadCmd");
        run_until_acks(1, 40, to);
        checks++; if (s_cyc.size() != want_str) $display("[TB] FAIL filter_strobes got %0d want %0d", s_cyc.size(), want_str); else passed++;
        checks++; if (to !== 1'b0 || a_cyc.size() != 1 || g_cyc.size() != 1) $display("[TB] FAIL filter_ack_count got %0d want 1", a_cyc.size()); else passed++;
        if (a_cyc.size() == 1 && g_cyc.size() == 1) begin
            checks++; if (a_cyc[0] - g_cyc[0] != want_lat) $display("[TB] FAIL filter_lat got %0d want %0d", a_cyc[0] - g_cyc[0], want_lat); else passed++;
            checks++; if (a_val[0] !== 4'b1000 || a_rsp[0] !== want_rsp) $display("[TB] FAIL filter_rsp got %b/%h want 1000/%h", a_val[0], a_rsp[0], want_rsp); else passed++;
        end
    endtask

    task automatic test_random();
        bit to;
        logic [NR-1:0] mask;
        logic [NR-1:0] one;
        int fwd_id [$];
        one = 1;
        for (int r = 0; r < 8; r++) begin
            clear_log();
            fwd_id.delete();
            mask = NR'($urandom_range(1, 15));
            for (int n = 0; n < NR; n++) if (mask[n]) set_term(n, UW'($urandom), int'($urandom_range(0, 7)));
            bus.i_req = mask;
            model_serve(mask);
            foreach (exp_id[i]) if (forwarded(term_k[exp_id[i]])) fwd_id.push_back(exp_id[i]);
            run_until_acks(exp_id.size(), 200, to);
            checks++; if (to !== 1'b0 || a_cyc.size() != exp_id.size() || g_cyc.size() != exp_id.size()) $display("[TB] FAIL rand%0d_acks got %0d/%0d want %0d", r, a_cyc.size(), g_cyc.size(), exp_id.size()); else passed++;
            checks++; if (s_cyc.size() != fwd_id.size()) $display("[TB] FAIL rand%0d_strobes got %0d want %0d", r, s_cyc.size(), fwd_id.size()); else passed++;
            for (int i = 0; i < a_cyc.size() && i < exp_id.size() && i < g_cyc.size(); i++) begin
                int id;
                int lat;
                logic [RW-1:0] rsp;
                id  = exp_id[i];
                lat = forwarded(term_k[id]) ? 3 + RESP_WAIT : 1;
                rsp = forwarded(term_k[id]) ? shop_resp(term_u[id], cmd_key(term_k[id])) : RW'("BadCmd");
                checks++; if (a_val[i] !== (one << id) || a_id[i] !== 3'(id)) $display("[TB] FAIL rand%0d_order[%0d] got %b/%0d want id %0d", r, i, a_val[i], a_id[i], id); else passed++;
                checks++; if (a_rsp[i] !== rsp) $display("[TB] FAIL rand%0d_rsp[%0d] got %h want %h", r, i, a_rsp[i], rsp); else passed++;
                checks++; if (a_cyc[i] - g_cyc[i] != lat) $display("[TB] FAIL rand%0d_lat[%0d] got %0d want %0d", r, i, a_cyc[i] - g_cyc[i], lat); else passed++;
            end
            for (int i = 0; i < s_cyc.size() && i < fwd_id.size(); i++) begin
                checks++; if (s_u[i] !== term_u[fwd_id[i]] || s_a[i] !== cmd_key(term_k[fwd_id[i]])) $display("[TB] FAIL rand%0d_shop[%0d] got %0d/%h", r, i, s_u[i], s_a[i]); else passed++;
            end
            bus.i_req = '0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_wrap();
        test_early_drop();
        test_reset_mid();
        test_filter();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
